// File: rtl/tpu_pkg.sv
// Shared constants for the tpuv1 host sequencer: the TPU register map and the
// sequencer state encoding.
package tpu_pkg;

  localparam logic [15:0] TPU_A_BASE = 16'h0100;
  localparam logic [15:0] TPU_B_BASE = 16'h0200;
  localparam logic [15:0] TPU_C_BASE = 16'h0300;
  localparam logic [15:0] TPU_START  = 16'h0400;
  localparam logic [15:0] TPU_IDLE   = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LD_A,
    ST_LD_B,
    ST_LD_C,
    ST_CLR_C,
    ST_START,
    ST_WAIT,
    ST_RD_C
  } seq_state_t;

  // Word address of row/half-row 'idx' inside a region; words are 8 bytes apart.
  function automatic logic [15:0] rowAddr(input logic [15:0] base, input logic [7:0] idx);
    return base + {5'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/tpuv1_host_seq.sv
// Bus initiator for the tpuv1 matrix unit: streams A, B and C (or zeros) into
// the TPU, issues start, waits out the compute time and streams C back out.
module tpuv1_host_seq
  import tpu_pkg::*;
#(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 3 * DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid,
  input  logic             job_load_c,
  output logic             job_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata,
  output logic             busy,
  output logic             done
);

  localparam int IDXW  = $clog2(2 * DIM) + 1;
  localparam int WCNTW = $clog2(WAIT_CYC) + 1;

  localparam logic [IDXW-1:0]  LAST_AB   = IDXW'(DIM - 1);
  localparam logic [IDXW-1:0]  LAST_C    = IDXW'(2 * DIM - 1);
  localparam logic [WCNTW-1:0] WAIT_INIT = WCNTW'(WAIT_CYC);

  seq_state_t       r_state, w_state;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic [WCNTW-1:0] r_wcnt, w_wcnt;
  logic             r_loadC, w_loadC;
  logic             r_rdPend, w_rdPend;
  logic [ADDRW-1:0] r_tpuAddr, w_tpuAddr;
  logic             r_tpuRw, w_tpuRw;
  logic [DATAW-1:0] r_tpuWdata, w_tpuWdata;
  logic             r_outValid, w_outValid;
  logic [DATAW-1:0] r_outData, w_outData;
  logic             w_done;
  logic             w_inReady;
  logic             w_jobReady;

  // Next-state and next-register values; the bus defaults to idle every cycle
  // so that a write is only ever driven for one cycle per accepted word.
  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_wcnt     = r_wcnt;
    w_loadC    = r_loadC;
    w_rdPend   = r_rdPend;
    w_tpuAddr  = ADDRW'(TPU_IDLE);
    w_tpuRw    = 1'b0;
    w_tpuWdata = '0;
    w_outValid = r_outValid;
    w_outData  = r_outData;
    w_done     = 1'b0;
    w_inReady  = 1'b0;
    w_jobReady = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_jobReady = 1'b1;
        if (job_valid) begin
          w_loadC = job_load_c;
          w_idx   = '0;
          w_state = ST_LD_A;
        end
      end

      ST_LD_A, ST_LD_B: begin
        w_inReady = 1'b1;
        if (in_valid) begin
          w_tpuRw    = 1'b1;
          w_tpuWdata = in_data;
          w_tpuAddr  = ADDRW'(rowAddr((r_state == ST_LD_A) ? TPU_A_BASE : TPU_B_BASE,
                                      8'(r_idx)));
          if (r_idx == LAST_AB) begin
            w_idx = '0;
            if (r_state == ST_LD_A) begin
              w_state = ST_LD_B;
            end else begin
              w_state = r_loadC ? ST_LD_C : ST_CLR_C;
            end
          end else begin
            w_idx = r_idx + IDXW'(1);
          end
        end
      end

      ST_LD_C: begin
        w_inReady = 1'b1;
        if (in_valid) begin
          w_tpuRw    = 1'b1;
          w_tpuWdata = in_data;
          w_tpuAddr  = ADDRW'(rowAddr(TPU_C_BASE, 8'(r_idx)));
          if (r_idx == LAST_C) begin
            w_idx   = '0;
            w_state = ST_START;
          end else begin
            w_idx = r_idx + IDXW'(1);
          end
        end
      end

      ST_CLR_C: begin
        w_tpuRw   = 1'b1;
        w_tpuAddr = ADDRW'(rowAddr(TPU_C_BASE, 8'(r_idx)));
        if (r_idx == LAST_C) begin
          w_idx   = '0;
          w_state = ST_START;
        end else begin
          w_idx = r_idx + IDXW'(1);
        end
      end

      ST_START: begin
        w_tpuRw   = 1'b1;
        w_tpuAddr = ADDRW'(TPU_START);
        w_wcnt    = WAIT_INIT;
        w_state   = ST_WAIT;
      end

      ST_WAIT: begin
        if (r_wcnt == '0) begin
          w_idx     = '0;
          w_rdPend  = 1'b0;
          w_tpuAddr = ADDRW'(rowAddr(TPU_C_BASE, 8'd0));
          w_state   = ST_RD_C;
        end else begin
          w_wcnt = r_wcnt - WCNTW'(1);
        end
      end

      ST_RD_C: begin
        w_tpuAddr = ADDRW'(rowAddr(TPU_C_BASE, 8'(r_idx)));
        if (!r_rdPend) begin
          w_outData  = tpu_rdata;
          w_outValid = 1'b1;
          w_rdPend   = 1'b1;
        end else if (out_ready) begin
          w_outValid = 1'b0;
          w_rdPend   = 1'b0;
          if (r_idx == LAST_C) begin
            w_done    = 1'b1;
            w_idx     = '0;
            w_tpuAddr = ADDRW'(TPU_IDLE);
            w_state   = ST_IDLE;
          end else begin
            w_idx     = r_idx + IDXW'(1);
            w_tpuAddr = ADDRW'(rowAddr(TPU_C_BASE, 8'(r_idx + IDXW'(1))));
          end
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Counters, latched job options and the registered bus/stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_wcnt     <= '0;
      r_loadC    <= 1'b0;
      r_rdPend   <= 1'b0;
      r_tpuAddr  <= '0;
      r_tpuRw    <= 1'b0;
      r_tpuWdata <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      r_idx      <= w_idx;
      r_wcnt     <= w_wcnt;
      r_loadC    <= w_loadC;
      r_rdPend   <= w_rdPend;
      r_tpuAddr  <= w_tpuAddr;
      r_tpuRw    <= w_tpuRw;
      r_tpuWdata <= w_tpuWdata;
      r_outValid <= w_outValid;
      r_outData  <= w_outData;
    end
  end

  assign job_ready = w_jobReady;
  assign in_ready  = w_inReady;
  assign busy      = (r_state != ST_IDLE);
  assign done      = w_done;
  assign tpu_addr  = r_tpuAddr;
  assign tpu_r_w   = r_tpuRw;
  assign tpu_wdata = r_tpuWdata;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;

endmodule

// File: tb/tb_tpuv1_host_seq.sv
// Bench for tpuv1_host_seq: a behavioural tpuv1 memory/compute model on the
// bus side, randomized job streams, and one negedge checker process that
// compares bus traffic and the C stream against a matrix-level model.
module tb_tpuv1_host_seq;

  localparam int DIM      = 8;
  localparam int WAIT_CYC = 3 * DIM;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_load_c;
  logic        job_ready;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] tpu_addr;
  logic        tpu_r_w;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;
  logic        busy;
  logic        done;

  tpuv1_host_seq #(.DIM(DIM), .DATAW(64), .ADDRW(16), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_load_c(job_load_c), .job_ready(job_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Job description (written by the stimulus, read by the checker).
  logic [63:0] jobA [8];
  logic [63:0] jobB [8];
  logic [63:0] jobC [16];
  logic        jobLoadC;
  logic [63:0] expOut [16];
  int          jobTag;
  logic        timeoutFlag;

  // Checker-owned state.
  int   errorCount = 0;
  int   checkCount = 0;
  int   rxCount = 0;
  int   wrIdx = 0;
  int   cyc = 0;
  int   startCyc = 0;
  logic startSeen = 1'b0;
  logic readSeen = 1'b0;
  logic prevDone = 1'b0;
  logic timeoutReported = 1'b0;

  // One C word (half-row w) = c0 + A*B over 8-bit A/B elements, 16-bit lanes.
  function automatic logic [63:0] cWord(input logic [63:0] a [8], input logic [63:0] b [8],
                                        input logic [63:0] c0, input int w);
    logic [63:0] r;
    logic [15:0] acc;
    int row;
    int col0;
    row  = w / 2;
    col0 = (w % 2) * 4;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      acc = c0[16*l +: 16];
      for (int k = 0; k < 8; k++) begin
        acc = acc + 16'(a[row][8*k +: 8]) * 16'(b[k][8*(col0+l) +: 8]);
      end
      r[16*l +: 16] = acc;
    end
    return r;
  endfunction

  // Behavioural tpuv1: register file plus instantaneous compute on start.
  logic [63:0] tpuA [8];
  logic [63:0] tpuB [8];
  logic [63:0] tpuC [16];

  always @(posedge clk) begin
    if (tpu_r_w && tpu_addr[2:0] == 3'd0) begin
      if (tpu_addr[15:8] == 8'h01 && tpu_addr[7:6] == 2'd0) tpuA[tpu_addr[5:3]] <= tpu_wdata;
      if (tpu_addr[15:8] == 8'h02 && tpu_addr[7:6] == 2'd0) tpuB[tpu_addr[5:3]] <= tpu_wdata;
      if (tpu_addr[15:8] == 8'h03 && tpu_addr[7] == 1'b0) tpuC[tpu_addr[6:3]] <= tpu_wdata;
      if (tpu_addr == 16'h0400) begin
        for (int w = 0; w < 16; w++) tpuC[w] <= cWord(tpuA, tpuB, tpuC[w], w);
      end
    end
  end

  always_comb begin
    tpu_rdata = '0;
    if (tpu_addr[15:8] == 8'h03 && tpu_addr[7] == 1'b0 && tpu_addr[2:0] == 3'd0)
      tpu_rdata = tpuC[tpu_addr[6:3]];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] expWrAddr(input int i);
    if (i < 8) return 64'(16'h0100 + 16'(8 * i));
    if (i < 16) return 64'(16'h0200 + 16'(8 * (i - 8)));
    return 64'(16'h0300 + 16'(8 * (i - 16)));
  endfunction

  function automatic logic [63:0] expWrData(input int i);
    if (i < 8) return jobA[i];
    if (i < 16) return jobB[i - 8];
    return jobLoadC ? jobC[i - 16] : 64'd0;
  endfunction

  // Single checker: reset values, bus ordering, start/wait gap, C stream, done.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      checkOutput("rstAddr", 64'(tpu_addr), 64'd0);
      checkOutput("rstRw", 64'(tpu_r_w), 64'd0);
      checkOutput("rstWdata", tpu_wdata, 64'd0);
      checkOutput("rstOutValid", 64'(out_valid), 64'd0);
      checkOutput("rstOutData", out_data, 64'd0);
      checkOutput("rstInReady", 64'(in_ready), 64'd0);
      checkOutput("rstDone", 64'(done), 64'd0);
      checkOutput("rstBusy", 64'(busy), 64'd0);
      checkOutput("rstJobReady", 64'(job_ready), 64'd1);
      rxCount = 0; wrIdx = 0; startSeen = 1'b0; readSeen = 1'b0; prevDone = 1'b0;
    end else begin
      if (job_valid && job_ready) begin
        rxCount = 0; wrIdx = 0; startSeen = 1'b0; readSeen = 1'b0;
        if (jobTag == 1) begin
          checkOutput("pinIdentityFirst", expOut[0], 64'h0004_0003_0002_0001);
          checkOutput("pinIdentityLast", expOut[15], 64'h0040_003f_003e_003d);
        end
        if (jobTag == 2) checkOutput("pin53", expOut[7], 64'h0035_0035_0035_0035);
      end

      if (tpu_r_w && tpu_addr == 16'h0400) begin
        checkOutput("startOnce", 64'(startSeen), 64'd0);
        checkOutput("startAfterWrites", 64'(wrIdx), 64'd32);
        startSeen = 1'b1;
        startCyc = cyc;
      end else if (tpu_r_w) begin
        if (wrIdx < 32) begin
          checkOutput("wrAddr", 64'(tpu_addr), expWrAddr(wrIdx));
          checkOutput("wrData", tpu_wdata, expWrData(wrIdx));
        end else begin
          checkOutput("extraWrite", 64'(tpu_addr), 64'd0);
        end
        wrIdx++;
      end else if (tpu_addr != 16'h0000 && !readSeen) begin
        checkOutput("startBeforeRead", 64'(startSeen), 64'd1);
        checkOutput("waitGap", 64'((cyc - startCyc - 1) >= WAIT_CYC), 64'd1);
        readSeen = 1'b1;
      end

      if (out_valid && rxCount < 16) begin
        checkOutput("outAddrHeld", 64'(tpu_addr), 64'(16'h0300 + 16'(8 * rxCount)));
        if (!out_ready) checkOutput("outDataHeld", out_data, expOut[rxCount]);
      end
      if (out_valid && out_ready) begin
        checkOutput("outData", out_data, (rxCount < 16) ? expOut[rxCount] : 64'hdead);
        checkOutput("done", 64'(done), 64'(rxCount == 15));
        rxCount++;
      end else if (done) begin
        checkOutput("doneStray", 64'(done), 64'd0);
      end

      if (prevDone) begin
        checkOutput("busyAfterDone", 64'(busy), 64'd0);
        checkOutput("readyAfterDone", 64'(job_ready), 64'd1);
      end
      prevDone = done;

      if (timeoutFlag && !timeoutReported) begin
        checkOutput("timeout", 64'd1, 64'd0);
        timeoutReported = 1'b1;
      end
    end
  end

  task automatic randomJob();
    for (int i = 0; i < 8; i++) begin
      for (int e = 0; e < 8; e++) begin
        jobA[i][8*e +: 8] = 8'($urandom_range(0, 15));
        jobB[i][8*e +: 8] = 8'($urandom_range(0, 15));
      end
    end
    for (int i = 0; i < 16; i++) jobC[i] = {$urandom, $urandom};
  endtask

  // Run one job: request, stream words (gapMode 0 none, 1 toggle, 2 random),
  // then either reset during WAIT or drain C with optional stall on stallWord.
  task automatic applyStimulus(input logic loadC, input int gapMode, input int stallWord,
                               input logic resetInWait);
    logic [63:0] words [32];
    int nw;
    int k;
    int n;
    int stallLeft;
    logic acc;
    logic v;

    jobLoadC = loadC;
    for (int w = 0; w < 16; w++) expOut[w] = cWord(jobA, jobB, loadC ? jobC[w] : 64'd0, w);
    for (int i = 0; i < 8; i++) begin
      words[i] = jobA[i];
      words[8 + i] = jobB[i];
    end
    for (int i = 0; i < 16; i++) words[16 + i] = jobC[i];
    nw = loadC ? 32 : 16;

    out_ready = 1'b1;
    job_valid = 1'b1;
    job_load_c = loadC;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      acc = job_ready;
      @(posedge clk); #1;
      n++;
    end
    job_valid = 1'b0;
    if (!acc) begin
      timeoutFlag = 1'b1;
      return;
    end

    k = 0;
    n = 0;
    while (k < nw && n < 2000) begin
      case (gapMode)
        0: v = 1'b1;
        1: v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data = v ? words[k] : {$urandom, $urandom};
      if (gapMode == 2) job_valid = 1'($urandom_range(0, 1));
      acc = v && in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) k++;
    end
    in_valid = 1'b0;
    job_valid = 1'b0;
    if (k < nw) begin
      timeoutFlag = 1'b1;
      return;
    end

    if (resetInWait) begin
      n = 0;
      while (tpu_addr != 16'h0400 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (tpu_addr != 16'h0400) timeoutFlag = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      return;
    end

    stallLeft = 10;
    n = 0;
    while (busy && n < 3000) begin
      if (stallWord >= 0 && rxCount == stallWord && stallLeft > 0) begin
        out_ready = 1'b0;
        if (out_valid) stallLeft--;
      end else begin
        out_ready = (gapMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    if (busy) timeoutFlag = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    job_valid = 1'b0;
    job_load_c = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    jobTag = 0;
    jobLoadC = 1'b0;
    timeoutFlag = 1'b0;
    for (int w = 0; w < 16; w++) expOut[w] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Identity A, B[k][j] = 8k+j+1, C cleared.
    for (int i = 0; i < 8; i++) begin
      jobA[i] = 64'd1 << (8 * i);
      for (int j = 0; j < 8; j++) jobB[i][8*j +: 8] = 8'(8 * i + j + 1);
    end
    for (int i = 0; i < 16; i++) jobC[i] = '0;
    jobTag = 1;
    applyStimulus(1'b0, 0, -1, 1'b0);

    // A all 2, B all 3, C preloaded with 5 -> 53 everywhere, toggled in_valid.
    for (int i = 0; i < 8; i++) begin
      jobA[i] = 64'h0202_0202_0202_0202;
      jobB[i] = 64'h0303_0303_0303_0303;
    end
    for (int i = 0; i < 16; i++) jobC[i] = 64'h0005_0005_0005_0005;
    jobTag = 2;
    applyStimulus(1'b1, 1, -1, 1'b0);

    // Random job with a 10-cycle stall on word 5.
    jobTag = 0;
    randomJob();
    applyStimulus(1'b1, 1, 5, 1'b0);

    // Reset during WAIT, then further random jobs must still be correct.
    randomJob();
    applyStimulus(1'b0, 2, -1, 1'b1);
    for (int r = 0; r < 3; r++) begin
      randomJob();
      applyStimulus(1'($urandom_range(0, 1)), 2, (r == 0) ? 3 : -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
